dac_spi_driver: RTL and testbench

DAC_SPI_DRIVER -- requirements
Module: dac_spi_driver

---
 rtl/dac_spi_driver.sv | 155 +++++++++++++++
 tb/tb_dac_spi_driver.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_driver.sv
// Dual-channel serial DAC driver: shifts two 12-bit codes out MSB first,
// padded to 16-bit frames, on a divided serial clock.
// Then it holds the frame strobe high for a configurable gap before signalling done.
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   start               frame request, level-sampled only while idle
//   sample_a, sample_b  12-bit channel codes, latched at frame acceptance
//   sclk, sync_n        serial clock (idles high) and active-low frame strobe
//   dina, dinb          serial data for channels A and B
//   busy, done          frame in progress / one-cycle completion pulse
module dac_spi_driver #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned FRAME_GAP = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] sample_a,
  input  logic [11:0] sample_b,
  output logic        sclk,
  output logic        sync_n,
  output logic        dina,
  output logic        dinb,
  output logic        busy,
  output logic        done
);

  localparam int unsigned DIV_W = 8;
  localparam int unsigned BIT_W = 4;
  localparam int unsigned GAP_W = 12;
  localparam int unsigned SR_W  = 16;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SR_W - 1);
  // Gap is counted in sclk half-periods so the counter stays small.
  localparam logic [GAP_W-1:0] GAP_LAST = (FRAME_GAP == 0) ? '0 : GAP_W'(2 * FRAME_GAP - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic [SR_W-1:0]   sr_a, sr_a_nxt, sr_b, sr_b_nxt;
  logic              sclk_nxt, sync_n_nxt, busy_nxt, done_nxt;

  // Data lines are the shift-register MSBs; registers are cleared outside a frame.
  assign dina = sr_a[SR_W-1];
  assign dinb = sr_b[SR_W-1];

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    div_cnt_nxt = div_cnt;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    sr_a_nxt    = sr_a;
    sr_b_nxt    = sr_b;
    sclk_nxt    = sclk;
    sync_n_nxt  = sync_n;
    busy_nxt    = busy;
    done_nxt    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = SHIFT;
          sr_a_nxt    = {4'b0000, sample_a};
          sr_b_nxt    = {4'b0000, sample_b};
          sync_n_nxt  = 1'b0;
          busy_nxt    = 1'b1;
          sclk_nxt    = 1'b1;
          div_cnt_nxt = '0;
          bit_cnt_nxt = '0;
        end
      end

      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nxt = '0;
          if (sclk) begin
            sclk_nxt = 1'b0;
          end else begin
            sclk_nxt = 1'b1;
            if (bit_cnt == BIT_LAST) begin
              // Rising edge after the 16th fall closes the frame.
              sr_a_nxt    = '0;
              sr_b_nxt    = '0;
              sync_n_nxt  = 1'b1;
              gap_cnt_nxt = '0;
              if (FRAME_GAP == 0) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
              end else begin
                state_nxt = GAP;
              end
            end else begin
              sr_a_nxt    = {sr_a[SR_W-2:0], 1'b0};
              sr_b_nxt    = {sr_b[SR_W-2:0], 1'b0};
              bit_cnt_nxt = bit_cnt + BIT_W'(1);
            end
          end
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end

      GAP: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nxt = '0;
          if (gap_cnt == GAP_LAST) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            gap_cnt_nxt = gap_cnt + GAP_W'(1);
          end
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      sr_a    <= '0;
      sr_b    <= '0;
      sclk    <= 1'b1;
      sync_n  <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      sr_a    <= sr_a_nxt;
      sr_b    <= sr_b_nxt;
      sclk    <= sclk_nxt;
      sync_n  <= sync_n_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_dac_spi_driver.sv
// Directed bench for dac_spi_driver: three instances (CLK_DIV/FRAME_GAP =
// 2/1, 1/0, 1/1) share stimulus; each scenario observes one instance.
module tb_dac_spi_driver;

  logic        clock;
  logic        reset;
  logic        start;
  logic [11:0] sample_a;
  logic [11:0] sample_b;
  logic [2:0]  sclk_w, sync_w, dina_w, dinb_w, busy_w, done_w;

  int n_tests = 0;
  int n_fail  = 0;

  dac_spi_driver #(.CLK_DIV(2), .FRAME_GAP(1)) dut0 (
    .clock(clock), .reset(reset), .start(start), .sample_a(sample_a), .sample_b(sample_b),
    .sclk(sclk_w[0]), .sync_n(sync_w[0]), .dina(dina_w[0]), .dinb(dinb_w[0]),
    .busy(busy_w[0]), .done(done_w[0]));

  dac_spi_driver #(.CLK_DIV(1), .FRAME_GAP(0)) dut1 (
    .clock(clock), .reset(reset), .start(start), .sample_a(sample_a), .sample_b(sample_b),
    .sclk(sclk_w[1]), .sync_n(sync_w[1]), .dina(dina_w[1]), .dinb(dinb_w[1]),
    .busy(busy_w[1]), .done(done_w[1]));

  dac_spi_driver #(.CLK_DIV(1), .FRAME_GAP(1)) dut2 (
    .clock(clock), .reset(reset), .start(start), .sample_a(sample_a), .sample_b(sample_b),
    .sclk(sclk_w[2]), .sync_n(sync_w[2]), .dina(dina_w[2]), .dinb(dinb_w[2]),
    .busy(busy_w[2]), .done(done_w[2]));

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs then reflect that edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Issue start for the next edge (t0); leaves start high.
  task automatic begin_frame();
    start = 1'b1;
    tick();
  endtask

  // Observe one frame of instance d from t0 until done (bounded by maxc edges).
  task automatic run_frame(input int d, input int maxc, input int chg_n, input logic [11:0] chg_val,
                           input int p1, input int p2, input logic hold,
                           output logic [15:0] a, output logic [15:0] b, output int done_at,
                           output int low_cnt, output int nfall, output int first_fall,
                           output int busy_at_done, output int sync_at_done);
    logic prev;
    a = '0; b = '0; done_at = -1; nfall = 0; first_fall = -1;
    busy_at_done = -1; sync_at_done = -1;
    low_cnt = (sync_w[d] == 1'b0) ? 1 : 0;
    prev = sclk_w[d];
    for (int n = 1; n <= maxc; n++) begin
      if (!hold) start = (n == p1) || (n == p2);
      if (n == chg_n) sample_a = chg_val;
      tick();
      if (prev && !sclk_w[d]) begin
        nfall++;
        a = {a[14:0], dina_w[d]};
        b = {b[14:0], dinb_w[d]};
        if (first_fall < 0) first_fall = n;
      end
      prev = sclk_w[d];
      if (done_w[d]) begin
        done_at = n;
        busy_at_done = busy_w[d];
        sync_at_done = sync_w[d];
        break;
      end
      if (!sync_w[d]) low_cnt++;
    end
    if (!hold) start = 1'b0;
  endtask

  logic [15:0] fa, fb;
  int done_at, low_cnt, nfall, first_fall, busy_d, sync_d, cnt, cnt2, done1;

  initial begin
    clock = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    sample_a = '0;
    sample_b = '0;

    // Reset state, and reset overriding start.
    start = 1'b1;
    tick();
    tick();
    check("rst_sclk",   sclk_w[0], 1);
    check("rst_sync_n", sync_w[0], 1);
    check("rst_dina",   dina_w[0], 0);
    check("rst_dinb",   dinb_w[0], 0);
    check("rst_busy",   busy_w[0], 0);
    check("rst_done",   done_w[0], 0);
    // First edge with reset low and start high is accepted.
    reset = 1'b0;
    sample_a = 12'h800;
    tick();
    check("first_accept_busy", busy_w[0], 1);
    check("first_accept_dina_bit15", dina_w[0], 0);
    do_reset();

    // Basic frame, CLK_DIV=2 FRAME_GAP=1.
    sample_a = 12'hABC;
    sample_b = 12'h123;
    begin_frame();
    check("t0_sync_n", sync_w[0], 0);
    check("t0_busy",   busy_w[0], 1);
    check("t0_sclk",   sclk_w[0], 1);
    start = 1'b0;
    run_frame(0, 200, -1, 12'h000, -1, -1, 1'b0, fa, fb, done_at, low_cnt, nfall, first_fall, busy_d, sync_d);
    check("f1_dina_bits", fa, 16'h0ABC);
    check("f1_dinb_bits", fb, 16'h0123);
    check("f1_done_at", done_at, 68);
    check("f1_sync_low_cycles", low_cnt, 64);
    check("f1_falls", nfall, 16);
    check("f1_first_fall", first_fall, 2);
    check("f1_busy_at_done", busy_d, 0);
    check("f1_sync_at_done", sync_d, 1);

    // Sample change mid-frame is not transmitted.
    do_reset();
    sample_a = 12'h555;
    begin_frame();
    start = 1'b0;
    run_frame(0, 200, 5, 12'hAAA, -1, -1, 1'b0, fa, fb, done_at, low_cnt, nfall, first_fall, busy_d, sync_d);
    check("latch_dina_bits", fa, 16'h0555);
    check("latch_done_at", done_at, 68);

    // Start pulses during a frame are ignored and not queued.
    do_reset();
    sample_a = 12'h0F0;
    begin_frame();
    start = 1'b0;
    run_frame(0, 200, -1, 12'h000, 10, 30, 1'b0, fa, fb, done_at, low_cnt, nfall, first_fall, busy_d, sync_d);
    check("ign_done_at", done_at, 68);
    check("ign_dina_bits", fa, 16'h00F0);
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (busy_w[0]) cnt++;
      if (done_w[0]) cnt2++;
    end
    check("ign_no_second_busy", cnt, 0);
    check("ign_no_second_done", cnt2, 0);

    // Reset mid-frame aborts with no done; new start accepted after release.
    do_reset();
    begin_frame();
    start = 1'b0;
    cnt = 0;
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (done_w[0]) cnt++;
    end
    reset = 1'b1;
    tick();
    check("abort_sync_n", sync_w[0], 1);
    check("abort_sclk",   sclk_w[0], 1);
    check("abort_busy",   busy_w[0], 0);
    check("abort_done",   done_w[0], 0);
    check("abort_no_done_before", cnt, 0);
    reset = 1'b0;
    sample_a = 12'h3C5;
    start = 1'b1;
    tick();
    check("abort_restart_busy", busy_w[0], 1);
    check("abort_restart_sync", sync_w[0], 0);
    start = 1'b0;
    run_frame(0, 200, -1, 12'h000, -1, -1, 1'b0, fa, fb, done_at, low_cnt, nfall, first_fall, busy_d, sync_d);
    check("abort_restart_done_at", done_at, 68);
    check("abort_restart_dina", fa, 16'h03C5);

    // Back-to-back frames, CLK_DIV=1 FRAME_GAP=0, start held high.
    do_reset();
    sample_a = 12'hFFF;
    sample_b = 12'h000;
    begin_frame();
    check("b2b_t0_busy", busy_w[1], 1);
    run_frame(1, 100, -1, 12'h000, -1, -1, 1'b1, fa, fb, done_at, low_cnt, nfall, first_fall, busy_d, sync_d);
    check("b2b_f1_done_at", done_at, 32);
    check("b2b_f1_dina", fa, 16'h0FFF);
    check("b2b_f1_sync_low", low_cnt, 32);
    check("b2b_f1_busy_at_done", busy_d, 0);
    check("b2b_f1_sync_at_done", sync_d, 1);
    done1 = done_at;
    sample_a = 12'h00F;
    tick();
    check("b2b_f2_accept_busy", busy_w[1], 1);
    run_frame(1, 100, -1, 12'h000, -1, -1, 1'b1, fa, fb, done_at, low_cnt, nfall, first_fall, busy_d, sync_d);
    check("b2b_f2_dina_relatched", fa, 16'h000F);
    check("b2b_done_period", 1 + done_at, 33);
    check("b2b_f1_reference", done1, 32);
    start = 1'b0;

    // CLK_DIV=1 FRAME_GAP=1.
    do_reset();
    sample_a = 12'h000;
    sample_b = 12'h800;
    begin_frame();
    start = 1'b0;
    run_frame(2, 100, -1, 12'h000, -1, -1, 1'b0, fa, fb, done_at, low_cnt, nfall, first_fall, busy_d, sync_d);
    check("div1_first_fall", first_fall, 1);
    check("div1_falls", nfall, 16);
    check("div1_dina", fa, 16'h0000);
    check("div1_dinb", fb, 16'h0800);
    check("div1_done_at", done_at, 34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
